// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared state encoding and sizing helpers for the burst write sequencer
package burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Enough bits to hold the value BURST_COUNT itself, not just BURST_COUNT-1.
    function automatic int burst_width(input int burst_count);
        return $clog2(burst_count) + 1;
    endfunction

endpackage

// File: rtl/burst_size_calc.sv
// rtl/burst_size_calc.sv - next burst length; boundary clipping under BURST_WRITE_SCHED_BOUNDARY_EN
module burst_size_calc
    import burst_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH  = 32,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int BURST_COUNT   = 8,
    parameter int BURST_WIDTH   = burst_width(BURST_COUNT),
    parameter int BOUNDARY_LOG2 = 6
) (
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [LENGTH_WIDTH-1:0]  remaining,
    output logic [BURST_WIDTH-1:0]   n
);

    localparam int BPW_LOG2 = $clog2(bytes_per_word(DATA_WIDTH));
    localparam int BND_W    = BOUNDARY_LOG2 + 1;

    logic [BURST_WIDTH-1:0] n_cap;
    logic [BND_W-1:0]       bytes_left;
    logic [BND_W-1:0]       words_left;
    logic                   unused_bits;

    always_comb begin
        n_cap = BURST_WIDTH'(BURST_COUNT);
        if (remaining < LENGTH_WIDTH'(BURST_COUNT)) begin
            n_cap = remaining[BURST_WIDTH-1:0];
        end
    end

    always_comb begin
        bytes_left = {1'b1, {BOUNDARY_LOG2{1'b0}}} - {1'b0, address[BOUNDARY_LOG2-1:0]};
        words_left = bytes_left >> BPW_LOG2;
    end

    assign unused_bits = ^{address, words_left};

`ifdef BURST_WRITE_SCHED_BOUNDARY_EN
    // words_left is only narrower than n_cap when it already fits in BURST_WIDTH.
    always_comb begin
        n = n_cap;
        if (words_left < BND_W'(n_cap)) begin
            n = words_left[BURST_WIDTH-1:0];
        end
    end
`else
    assign n = n_cap;
`endif

endmodule

// File: rtl/burst_write_sched.sv
// rtl/burst_write_sched.sv - splits a transfer command into write-master bursts (BURST_WRITE_SCHED_BOUNDARY_EN clips at boundaries)
module burst_write_sched
    import burst_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LENGTH_WIDTH  = 32,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int BURST_COUNT   = 8,
    parameter int BURST_WIDTH   = burst_width(BURST_COUNT),
    parameter int BOUNDARY_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_start,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [LENGTH_WIDTH-1:0]  cmd_length,
    input  logic                     cmd_abort,
    output logic                     cmd_busy,
    output logic                     cmd_done,
    output logic                     cmd_aborted,
    output logic                     burst_start,
    output logic [ADDRESS_WIDTH-1:0] burst_address,
    output logic [BURST_WIDTH-1:0]   burst_count,
    input  logic                     burst_busy
);

    localparam int BPW_LOG2 = $clog2(bytes_per_word(DATA_WIDTH));

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
    logic                     abort_pend_q, abort_pend_d;
    logic                     cmd_busy_q, cmd_busy_d;
    logic                     cmd_done_q, cmd_done_d;
    logic                     cmd_aborted_q, cmd_aborted_d;
    logic                     burst_start_q, burst_start_d;
    logic [ADDRESS_WIDTH-1:0] burst_address_q, burst_address_d;
    logic [BURST_WIDTH-1:0]   burst_count_q, burst_count_d;

    logic [ADDRESS_WIDTH-1:0] calc_addr;
    logic [LENGTH_WIDTH-1:0]  calc_rem;
    logic [BURST_WIDTH-1:0]   size_n;
    logic                     abort_seen;
    logic                     go_issue;

    // Address/remaining the next burst would start from: the new command in
    // IDLE, otherwise the current burst retired. Kept apart to avoid a loop.
    always_comb begin
        if (state_q == ST_IDLE) begin
            calc_addr = cmd_address;
            calc_rem  = cmd_length;
        end else begin
            calc_addr = addr_q + (ADDRESS_WIDTH'(burst_count_q) << BPW_LOG2);
            calc_rem  = remaining_q - LENGTH_WIDTH'(burst_count_q);
        end
    end

    burst_size_calc #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LENGTH_WIDTH  (LENGTH_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .BURST_COUNT   (BURST_COUNT),
        .BURST_WIDTH   (BURST_WIDTH),
        .BOUNDARY_LOG2 (BOUNDARY_LOG2)
    ) u_size (
        .address   (calc_addr),
        .remaining (calc_rem),
        .n         (size_n)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        abort_pend_d    = abort_pend_q;
        cmd_busy_d      = cmd_busy_q;
        cmd_done_d      = 1'b0;
        cmd_aborted_d   = 1'b0;
        burst_start_d   = 1'b0;
        burst_address_d = burst_address_q;
        burst_count_d   = burst_count_q;
        go_issue        = 1'b0;
        abort_seen      = abort_pend_q | cmd_abort;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (cmd_start) begin
                    cmd_busy_d = 1'b1;
                    if (cmd_length != '0) begin
                        addr_d      = calc_addr;
                        remaining_d = calc_rem;
                        go_issue    = 1'b1;
                        state_d     = ST_ISSUE;
                    end else begin
                        cmd_done_d = 1'b1;
                        state_d    = ST_FINISH;
                    end
                end
            end
            ST_ISSUE: begin
                abort_pend_d = abort_seen;
                state_d      = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                abort_pend_d = abort_seen;
                if (burst_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                abort_pend_d = abort_seen;
                if (!burst_busy) begin
                    addr_d      = calc_addr;
                    remaining_d = calc_rem;
                    if (calc_rem == '0 || abort_seen) begin
                        cmd_done_d    = 1'b1;
                        cmd_aborted_d = abort_seen;
                        state_d       = ST_FINISH;
                    end else begin
                        go_issue = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                cmd_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                cmd_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        if (go_issue) begin
            burst_start_d   = 1'b1;
            burst_address_d = calc_addr;
            burst_count_d   = size_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            abort_pend_q    <= 1'b0;
            cmd_busy_q      <= 1'b0;
            cmd_done_q      <= 1'b0;
            cmd_aborted_q   <= 1'b0;
            burst_start_q   <= 1'b0;
            burst_address_q <= '0;
            burst_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            abort_pend_q    <= abort_pend_d;
            cmd_busy_q      <= cmd_busy_d;
            cmd_done_q      <= cmd_done_d;
            cmd_aborted_q   <= cmd_aborted_d;
            burst_start_q   <= burst_start_d;
            burst_address_q <= burst_address_d;
            burst_count_q   <= burst_count_d;
        end
    end

    assign cmd_busy      = cmd_busy_q;
    assign cmd_done      = cmd_done_q;
    assign cmd_aborted   = cmd_aborted_q;
    assign burst_start   = burst_start_q;
    assign burst_address = burst_address_q;
    assign burst_count   = burst_count_q;

endmodule

// File: tb/tb_burst_write_sched.sv
// tb/tb_burst_write_sched.sv - directed self-checking bench for burst_write_sched
module tb_burst_write_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start;
    logic [31:0] cmd_address;
    logic [31:0] cmd_length;
    logic        cmd_abort;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_aborted;
    logic        burst_start;
    logic [31:0] burst_address;
    logic [3:0]  burst_count;
    logic        burst_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    burst_write_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_start     (cmd_start),
        .cmd_address   (cmd_address),
        .cmd_length    (cmd_length),
        .cmd_abort     (cmd_abort),
        .cmd_busy      (cmd_busy),
        .cmd_done      (cmd_done),
        .cmd_aborted   (cmd_aborted),
        .burst_start   (burst_start),
        .burst_address (burst_address),
        .burst_count   (burst_count),
        .burst_busy    (burst_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse cmd_start; returns at the negedge where the first burst_start is due.
    task automatic start_cmd(input logic [31:0] addr, input logic [31:0] len);
        cmd_start   = 1'b1;
        cmd_address = addr;
        cmd_length  = len;
        @(negedge clk);
        cmd_start   = 1'b0;
    endtask

    // Called at the negedge where burst_start must be high; plays the write
    // master and returns at the negedge where the following event is due.
    task automatic expect_burst(input string tag, input logic [31:0] addr, input logic [31:0] cnt,
                                input bit abort_in, input bit start_in);
        check({tag, "_start"}, {31'd0, burst_start}, 32'd1);
        check({tag, "_addr"}, burst_address, addr);
        check({tag, "_count"}, {28'd0, burst_count}, cnt);
        check({tag, "_busy"}, {31'd0, cmd_busy}, 32'd1);
        burst_busy = 1'b1;
        @(negedge clk);
        check({tag, "_pulse_len"}, {31'd0, burst_start}, 32'd0);
        if (start_in) begin
            cmd_start   = 1'b1;
            cmd_address = 32'hDEAD_0000;
            cmd_length  = 32'd3;
        end
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_abort = abort_in;
        @(negedge clk);
        cmd_abort  = 1'b0;
        burst_busy = 1'b0;
        check({tag, "_hold_addr"}, burst_address, addr);
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag, input logic exp_aborted);
        check({tag, "_done"}, {31'd0, cmd_done}, 32'd1);
        check({tag, "_aborted"}, {31'd0, cmd_aborted}, {31'd0, exp_aborted});
        check({tag, "_no_burst"}, {31'd0, burst_start}, 32'd0);
        check({tag, "_busy_at_done"}, {31'd0, cmd_busy}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, cmd_done}, 32'd0);
        check({tag, "_idle"}, {31'd0, cmd_busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, cmd_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, cmd_done}, 32'd0);
        check({tag, "_aborted"}, {31'd0, cmd_aborted}, 32'd0);
        check({tag, "_bstart"}, {31'd0, burst_start}, 32'd0);
        check({tag, "_baddr"}, burst_address, 32'd0);
        check({tag, "_bcount"}, {28'd0, burst_count}, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        cmd_start   = 1'b0;
        cmd_address = 32'd0;
        cmd_length  = 32'd0;
        cmd_abort   = 1'b0;
        burst_busy  = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        start_cmd(32'h3800_0000, 32'd20);
        expect_burst("split_b0", 32'h3800_0000, 32'd8, 1'b0, 1'b0);
        expect_burst("split_b1", 32'h3800_0020, 32'd8, 1'b0, 1'b0);
        expect_burst("split_b2", 32'h3800_0040, 32'd4, 1'b0, 1'b0);
        expect_done("split", 1'b0);

        start_cmd(32'h3800_0030, 32'd8);
`ifdef BURST_WRITE_SCHED_BOUNDARY_EN
        expect_burst("bnd_b0", 32'h3800_0030, 32'd4, 1'b0, 1'b0);
        expect_burst("bnd_b1", 32'h3800_0040, 32'd4, 1'b0, 1'b0);
`else
        expect_burst("bnd_b0", 32'h3800_0030, 32'd8, 1'b0, 1'b0);
`endif
        expect_done("bnd", 1'b0);

        start_cmd(32'h3800_0100, 32'd0);
        expect_done("zero", 1'b0);
        check("zero_after", {31'd0, burst_start}, 32'd0);

        start_cmd(32'h0000_1000, 32'd32);
        expect_burst("abort_b0", 32'h0000_1000, 32'd8, 1'b0, 1'b0);
        expect_burst("abort_b1", 32'h0000_1020, 32'd8, 1'b1, 1'b0);
        expect_done("abort", 1'b1);

        start_cmd(32'h0000_2000, 32'd12);
        expect_burst("sbusy_b0", 32'h0000_2000, 32'd8, 1'b0, 1'b1);
        expect_burst("sbusy_b1", 32'h0000_2020, 32'd4, 1'b0, 1'b0);
        expect_done("sbusy", 1'b0);
        check("sbusy_quiet", {31'd0, burst_start}, 32'd0);

        start_cmd(32'hFFFF_FFE0, 32'd12);
        expect_burst("wrap_b0", 32'hFFFF_FFE0, 32'd8, 1'b0, 1'b0);
        expect_burst("wrap_b1", 32'h0000_0000, 32'd4, 1'b0, 1'b0);
        expect_done("wrap", 1'b0);

        start_cmd(32'h0000_3000, 32'd16);
        check("rst_b0_start", {31'd0, burst_start}, 32'd1);
        burst_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        burst_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_no_reissue", {31'd0, burst_start}, 32'd0);
            check("post_reset_idle", {31'd0, cmd_busy}, 32'd0);
        end
        start_cmd(32'h0000_4000, 32'd8);
        expect_burst("after_rst_b0", 32'h0000_4000, 32'd8, 1'b0, 1'b0);
        expect_done("after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_write_sched.md
# burst_write_sched

Command sequencer in front of the Avalon-MM burst write master. Accepts one transfer command (byte base address plus length in words), splits it into consecutive bursts of at most `BURST_COUNT` words, and drives the write master's start/address/burstcount/busy control handshake one burst at a time. It sits between the frame/DMA control logic and the write master, so upstream logic never deals with burst granularity.

## Interface
- `ADDRESS_WIDTH`, 32: byte address width.
- `LENGTH_WIDTH`, 32: width of the word-count field; must be ≤ `ADDRESS_WIDTH`.
- `DATA_WIDTH`, 32: master data width; bytes per word = `DATA_WIDTH/8`.
- `BURST_COUNT`, 8: maximum words per burst, power of 2, range 1–1024.
- `BURST_WIDTH`, 4: width needed to hold `BURST_COUNT`, equal to log2(`BURST_COUNT`)+1.
- `BOUNDARY_LOG2`, 6: byte boundary that a burst must not cross, expressed as log2 of the boundary size. Used only with `BURST_WRITE_SCHED_BOUNDARY_EN`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_start` in 1: one-cycle request; sampled only in IDLE.
- `cmd_address` in `ADDRESS_WIDTH`: byte base address; word-aligned.
- `cmd_length` in `LENGTH_WIDTH`: total words to write.
- `cmd_abort` in 1: level; stop after the in-flight burst.
- `cmd_busy` out 1: high from the cycle after an accepted start until the cycle of `cmd_done`, inclusive.
- `cmd_done` out 1: one-cycle completion pulse.
- `cmd_aborted` out 1: valid with `cmd_done`; 1 if the transfer ended early.
- `burst_start` out 1: one-cycle launch pulse to the write master.
- `burst_address` out `ADDRESS_WIDTH`: byte address of the current burst.
- `burst_count` out `BURST_WIDTH`: word count of the current burst, from 1 to `BURST_COUNT`.
- `burst_busy` in 1: busy flag from the write master.

## Operation
- States:
  - IDLE: wait for `cmd_start`.
  - ISSUE: drive the `burst_start` pulse.
  - WAIT_ACK: wait for `burst_busy` to be 1.
  - WAIT_DONE: wait for `burst_busy` to be 0.
  - FINISH: drive the `cmd_done` pulse, then return to IDLE.
- IDLE:
  - `cmd_start` with `cmd_length` ≠ 0: latch the address, set `remaining` = `cmd_length`, go to ISSUE.
  - `cmd_start` with `cmd_length` = 0: go directly to FINISH; no burst is issued.
- ISSUE:
  - Burst size n = min(`remaining`, `BURST_COUNT`).
  - Register n on `burst_count` and the current address on `burst_address`.
  - Pulse `burst_start`, then go to WAIT_ACK.
- WAIT_ACK → WAIT_DONE when `burst_busy` = 1.
- WAIT_DONE, on `burst_busy` = 0:
  - address += n × (`DATA_WIDTH`/8) and `remaining` −= n.
  - If `remaining` = 0 or an abort is pending, go to FINISH.
  - Otherwise go to ISSUE.
- Abort: `cmd_abort` is sampled in any non-IDLE state and sets a sticky pending flag.
  - The in-flight burst always completes; the block never truncates a burst already launched.
  - `cmd_aborted` = 1 with `cmd_done`.
  - The pending flag clears in IDLE.
- `cmd_start` while `cmd_busy` is high is ignored.
- The address counter wraps modulo 2^`ADDRESS_WIDTH`. No error is flagged.
- Reset (asynchronous, at any point including mid-burst): all outputs are 0, the state is IDLE, and the internal counters are 0. The block does not re-issue a burst after reset.

## Timing
- `cmd_start` sampled in cycle T → `burst_start` = 1 in cycle T+1, with `burst_address`/`burst_count` valid in the same cycle.
- `burst_address` and `burst_count` are held stable until the next `burst_start`.
- `burst_busy` falling observed in cycle U:
  - next `burst_start` in U+1, or
  - `cmd_done` in U+1 on the last burst.
- Gap between bursts: 1 idle cycle minimum. Throughput is bounded by the write master.
- Zero-length command: `cmd_done` in T+1.
- All outputs are registered.

## Configuration
- `BURST_WRITE_SCHED_BOUNDARY_EN` defined:
  - n = min(`remaining`, `BURST_COUNT`, words to the next 2^`BOUNDARY_LOG2` byte boundary).
  - Words to the boundary = (2^`BOUNDARY_LOG2` − (address mod 2^`BOUNDARY_LOG2`)) / (`DATA_WIDTH`/8).
  - Requirement: 2^`BOUNDARY_LOG2` ≥ `BURST_COUNT` × bytes per word.
- Macro undefined: no boundary term; bursts may cross any address.

## Structure
- Shared package `burst_pkg`:
  - state encoding (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT_ACK`, `ST_WAIT_DONE`, `ST_FINISH`);
  - bytes-per-word constant;
  - the `BURST_WIDTH` derivation function.
- One combinational sub-module, `burst_size_calc`: computes n from `remaining`, the address, and the macro-dependent boundary term. Instantiated once.

## Test plan
- Basic split: `BURST_COUNT`=8, `cmd_address`=0x38000000, `cmd_length`=20 → bursts of 8 words @0x38000000, 8 @0x38000020, 4 @0x38000040; then one `cmd_done` with `cmd_aborted`=0.
- Boundary, macro on (`BOUNDARY_LOG2`=6): address 0x38000030, length 8 → bursts of 4 @0x38000030 and 4 @0x38000040. Macro off: a single burst of 8 @0x38000030.
- Zero length: `cmd_start` with `cmd_length`=0 → `cmd_done` in the next cycle, no `burst_start`.
- Abort: length 32, `cmd_abort` pulsed during the 2nd burst's WAIT_DONE → exactly 2 bursts, then `cmd_done` with `cmd_aborted`=1.
- Start while busy: a second `cmd_start` during WAIT_ACK → ignored; burst sequence unchanged.
- Reset: `reset_n` low mid-transfer → all outputs 0 immediately. After release, a new command of length 8 → one burst of 8 at the new address.
